// File: rtl/csa_accum_ctrl.sv
// Sequential multi-operand unsigned accumulator built around one shared 3:2 carry-save row.
// The running total stays redundant (S, C) and is resolved by iterating the row with a zero third input.
module csa_accum_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] rcar;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    maj     = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);
    rcar    = s_q & c_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          s_d   = s_q ^ c_q ^ in_data;
          // Carry out of the top bit is worth exactly 2^WIDTH: fold it into ovf.
          c_d   = {maj[WIDTH-2:0], 1'b0};
          ovf_d = ovf_q | maj[WIDTH-1];
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (c_q == '0) begin
          state_d = ST_OUT;
        end else begin
          s_d   = s_q ^ c_q;
          c_d   = {rcar[WIDTH-2:0], 1'b0};
          ovf_d = ovf_q | rcar[WIDTH-1];
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_sum   = s_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: two instances (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_csa_accum_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_ovf_a;
  logic [7:0] out_sum_a, out_count_a;
  logic       in_ready_b, out_valid_b, out_ovf_b;
  logic [7:0] out_sum_b;
  logic [1:0] out_count_b;

  int unsigned n_cmp;
  int unsigned n_bad;

  csa_accum_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  csa_accum_ctrl #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand for exactly one handshake edge.
  task automatic send(input logic [7:0] d, input logic last);
    chk("in_ready_before_send", in_ready_a, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // Wait (bounded) for out_valid, check result and latency, then complete the output handshake.
  task automatic drain(input string tag, input logic [7:0] e_sum, input logic [7:0] e_cnt,
                       input logic e_ovf, input logic [1:0] e_cnt_sat, input int e_lat);
    int cyc;
    cyc = 0;
    while (!out_valid_a && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_valid"}, out_valid_a, 1);
    if (e_lat > 0) chk({tag, "_latency"}, cyc, e_lat);
    chk({tag, "_sum"}, out_sum_a, e_sum);
    chk({tag, "_count"}, out_count_a, e_cnt);
    chk({tag, "_ovf"}, out_ovf_a, e_ovf);
    chk({tag, "_in_ready_low"}, in_ready_a, 0);
    chk({tag, "_sat_valid"}, out_valid_b, 1);
    chk({tag, "_sat_sum"}, out_sum_b, e_sum);
    chk({tag, "_sat_count"}, out_count_b, e_cnt_sat);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_cleared"}, out_valid_a, 0);
    chk({tag, "_in_ready_back"}, in_ready_a, 1);
    chk({tag, "_cleared_count"}, out_count_a, 0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_sum", out_sum_a, 0);
    chk("rst_out_count", out_count_a, 0);
    chk("rst_out_ovf", out_ovf_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3 + 5 + 7: redundant pair 3/0, 6/2, 3/12, one resolve step
    send(8'd3, 1'b0);
    chk("s1_S0", dut.s_q, 3);
    chk("s1_C0", dut.c_q, 0);
    send(8'd5, 1'b0);
    chk("s1_S1", dut.s_q, 6);
    chk("s1_C1", dut.c_q, 2);
    send(8'd7, 1'b1);
    chk("s1_S2", dut.s_q, 3);
    chk("s1_C2", dut.c_q, 12);
    chk("s1_in_ready_resolve", in_ready_a, 0);
    drain("s1", 8'd15, 8'd3, 1'b0, 2'd3, 2);

    // Single operand: C is already zero, one RESOLVE cycle
    send(8'hAA, 1'b1);
    drain("s2", 8'hAA, 8'd1, 1'b0, 2'd1, 1);

    // 0xFF + 0x01: carry ripples through 7 resolve steps and drops off the top
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    chk("s3_C_first", dut.c_q, 8'h02);
    drain("s3", 8'h00, 8'd2, 1'b1, 2'd2, 8);

    // Backpressure: outputs held and inputs refused while out_ready is low
    send(8'd3, 1'b0);
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    begin
      int cyc;
      cyc = 0;
      while (!out_valid_a && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("s4_hold_valid", out_valid_a, 1);
      chk("s4_hold_sum", out_sum_a, 15);
      chk("s4_hold_count", out_count_a, 3);
      chk("s4_hold_in_ready", in_ready_a, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain("s4", 8'd15, 8'd3, 1'b0, 2'd3, 0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b1);
    drain("s4b", 8'd2, 8'd2, 1'b0, 2'd2, 0);

    // Six ones: narrow counter saturates at 3, wide one reaches 6
    for (int i = 0; i < 6; i++) send(8'd1, (i == 5));
    drain("s5", 8'd6, 8'd6, 1'b0, 2'd3, 0);

    // Asynchronous reset in the middle of resolving 0xFF + 0x01
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    @(posedge clk);
    #1;
    chk("s6_in_resolve", in_ready_a, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", out_valid_a, 0);
    chk("s6_rst_sum", out_sum_a, 0);
    chk("s6_rst_count", out_count_a, 0);
    chk("s6_rst_ovf", out_ovf_a, 0);
    chk("s6_rst_in_ready", in_ready_a, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'd4, 1'b1);
    drain("s6", 8'd4, 8'd1, 1'b0, 2'd1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
